// File: rtl/meta_tag_array.sv
// Purpose  : L1 D-cache metadata tag store, N_SETS x N_WAYS entries of {valid, tag},
//            cleared by an internal init sequencer after reset.
// Latency  : one cycle from read fire to io_resp_valid; a write is visible to reads firing on later edges.
// Backpress: both readies low during init; single-port build stalls reads while a write is valid;
//            the response channel has no backpressure.
//
// Compile-time option: META_DUAL_PORT_EN
//   undefined : single-port array, a pending write always wins over a read.
//   defined   : independent read and write ports. A same-set collision returns the pre-write contents.
//
// Ports:
//   clock, reset                  rising-edge clock; synchronous active-low reset
//   io_write_{ready,valid,bits_*} arbitrated metadata write (idx, way_en, tag)
//   io_read_{ready,valid,bits_idx} tag lookup request
//   io_resp_{valid,bits_tag,bits_valid} lookup result, way 0 in the LSBs
//   io_init_done                  high once every set has been cleared
module meta_tag_array #(
   parameter int N_SETS = 64,
   parameter int N_WAYS = 4,
   parameter int IDX_W  = 6,
   parameter int TAG_W  = 20
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      io_write_ready,
   input  logic                      io_write_valid,
   input  logic [IDX_W-1:0]          io_write_bits_idx,
   input  logic [N_WAYS-1:0]         io_write_bits_way_en,
   input  logic [TAG_W-1:0]          io_write_bits_tag,
   output logic                      io_read_ready,
   input  logic                      io_read_valid,
   input  logic [IDX_W-1:0]          io_read_bits_idx,
   output logic                      io_resp_valid,
   output logic [N_WAYS*TAG_W-1:0]   io_resp_bits_tag,
   output logic [N_WAYS-1:0]         io_resp_bits_valid,
   output logic                      io_init_done
);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // The init counter is one bit wider than the set index; it stops at N_SETS and never wraps.
   localparam logic [IDX_W:0] LAST_SET = (IDX_W+1)'(N_SETS - 1);

   // ------------------------------------------------------------------
   // Control / response state
   // ------------------------------------------------------------------
   state_e                    state_q, state_d;
   logic [IDX_W:0]            init_cnt_q, init_cnt_d;
   logic                      resp_vld_q, resp_vld_d;
   logic [N_WAYS*TAG_W-1:0]   resp_tag_q, resp_tag_d;
   logic [N_WAYS-1:0]         resp_way_vld_q, resp_way_vld_d;

   // ------------------------------------------------------------------
   // Storage and its single write port
   // ------------------------------------------------------------------
   logic [TAG_W-1:0]          tag_arr_q [N_SETS][N_WAYS];
   logic                      vld_arr_q [N_SETS][N_WAYS];

   logic [N_WAYS-1:0]         arr_we;
   logic [IDX_W-1:0]          arr_idx;
   logic [TAG_W-1:0]          arr_tag;
   logic                      arr_vld;

   logic                      is_ready;
   logic                      wr_fire;
   logic                      rd_fire;

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   always_comb begin
      is_ready       = (state_q == ST_READY);
      io_write_ready = is_ready;
      io_init_done   = is_ready;
`ifdef META_DUAL_PORT_EN
      io_read_ready  = is_ready;
`else
      // A single array port: a valid write steals the port, so this path is combinational.
      io_read_ready  = is_ready & ~io_write_valid;
`endif
      wr_fire        = io_write_valid & io_write_ready;
      rd_fire        = io_read_valid & io_read_ready;
   end

   // ------------------------------------------------------------------
   // Next-state, array write port and response
   // ------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      init_cnt_d     = init_cnt_q;
      arr_we         = '0;
      arr_idx        = io_write_bits_idx;
      arr_tag        = io_write_bits_tag;
      arr_vld        = 1'b1;
      resp_vld_d     = rd_fire;
      resp_tag_d     = resp_tag_q;
      resp_way_vld_d = resp_way_vld_q;

      case (state_q)
         ST_INIT: begin
            // Clear one whole set per cycle. Upstream requests are not accepted here.
            arr_we     = '1;
            arr_idx    = init_cnt_q[IDX_W-1:0];
            arr_tag    = '0;
            arr_vld    = 1'b0;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_SET) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            // An all-zero way mask still completes the handshake but leaves the array unchanged.
            if (wr_fire) begin
               arr_we = io_write_bits_way_en;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // An edge with reset asserted never modifies storage.
      if (!reset) begin
         arr_we = '0;
      end

      // The array is read with its current contents. A same-edge write therefore is not visible,
      // which gives read-before-write on a dual-port collision.
      if (rd_fire) begin
         for (int w = 0; w < N_WAYS; w++) begin
            resp_tag_d[w*TAG_W +: TAG_W] = tag_arr_q[io_read_bits_idx][w];
            resp_way_vld_d[w]            = vld_arr_q[io_read_bits_idx][w];
         end
      end
   end

   // ------------------------------------------------------------------
   // Control flops with synchronous active-low reset
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= ST_INIT;
         init_cnt_q     <= '0;
         resp_vld_q     <= 1'b0;
         resp_tag_q     <= '0;
         resp_way_vld_q <= '0;
      end else begin
         state_q        <= state_d;
         init_cnt_q     <= init_cnt_d;
         resp_vld_q     <= resp_vld_d;
         resp_tag_q     <= resp_tag_d;
         resp_way_vld_q <= resp_way_vld_d;
      end
   end

   // ------------------------------------------------------------------
   // Storage: no reset; the init sequencer clears it
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      for (int w = 0; w < N_WAYS; w++) begin
         if (arr_we[w]) begin
            tag_arr_q[arr_idx][w] <= arr_tag;
            vld_arr_q[arr_idx][w] <= arr_vld;
         end
      end
   end

   assign io_resp_valid      = resp_vld_q;
   assign io_resp_bits_tag   = resp_tag_q;
   assign io_resp_bits_valid = resp_way_vld_q;

endmodule
